audio_out: RTL and testbench

AUDIO_OUT -- requirements
Module: audio_out

---
 rtl/audio_out.sv | 143 ++++++++++++++
 tb/tb_audio_out.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out.sv
// Audio output stage: sample-rate divider, click-free fade in/out gain ramp,
// and a first-order sigma-delta modulator that turns the gain-scaled sample into a 1-bit stream.
module audio_out #(
  parameter int CLK_DIV      = 1536,
  parameter int RAMP_SAMPLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sample,
  input  logic       mute,
  output logic       sample_ena,
  output logic       pdm,
  output logic [3:0] level,
  output logic       muted
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_SAMPLES - 1);

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    PLAY,
    RAMP_DOWN
  } fade_e;

  fade_e            state_q, state_d;
  logic [DW-1:0]    divider_q, divider_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       gain_q, gain_d;
  logic [3:0]       sample_q, sample_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       acc_q, acc_d;
  logic             pdm_q, pdm_d;
  logic             stepDone;
  logic signed [9:0] centered, product, scaled;
  logic [4:0]       pdmSum;

  // Sample-rate divider; the strobe marks the last clock of each sample period.
  always_comb begin
    sample_ena = (divider_q == DIV_LAST);
    divider_d  = sample_ena ? '0 : divider_q + 1'b1;
    sample_d   = sample_ena ? sample : sample_q;
  end

  // Scale around the silence midpoint so gain 0 lands exactly on 8; the shift floors.
  always_comb begin
    centered = signed'({6'd0, sample_q}) - 10'sd8;
    product  = centered * signed'({6'd0, gain_q});
    scaled   = (product >>> 4) + 10'sd8;
    level_d  = scaled[3:0];
  end

  // Fade FSM; mute is only looked at on strobes, and every state change clears the prescaler.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    presc_d  = presc_q;
    stepDone = (presc_q == PRE_LAST);
    if (sample_ena) begin
      case (state_q)
        MUTED: begin
          if (!mute) begin
            state_d = RAMP_UP;
            presc_d = '0;
          end
        end
        RAMP_UP: begin
          if (mute) begin
            state_d = (gain_q == 4'd0) ? MUTED : RAMP_DOWN;
            presc_d = '0;
          end else if (stepDone) begin
            presc_d = '0;
            gain_d  = gain_q + 4'd1;
            if (gain_q == 4'd14) state_d = PLAY;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PLAY: begin
          if (mute) begin
            state_d = RAMP_DOWN;
            presc_d = '0;
          end
        end
        RAMP_DOWN: begin
          // A reversal at full gain has nothing left to ramp, so it settles straight back in PLAY.
          if (!mute) begin
            state_d = (gain_q == 4'd15) ? PLAY : RAMP_UP;
            presc_d = '0;
          end else if (stepDone) begin
            presc_d = '0;
            gain_d  = gain_q - 4'd1;
            if (gain_q == 4'd1) state_d = MUTED;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = MUTED;
          gain_d  = 4'd0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Sigma-delta: the accumulator carry is the output bit, so ones-density equals level/16.
  always_comb begin
    pdmSum = {1'b0, acc_q} + {1'b0, level_q};
    acc_d  = pdmSum[3:0];
    pdm_d  = pdmSum[4];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MUTED;
      divider_q <= '0;
      presc_q   <= '0;
      gain_q    <= 4'd0;
      sample_q  <= 4'd8;
      level_q   <= 4'd8;
      acc_q     <= 4'd0;
      pdm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divider_q <= divider_d;
      presc_q   <= presc_d;
      gain_q    <= gain_d;
      sample_q  <= sample_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
      pdm_q     <= pdm_d;
    end
  end

  assign level = level_q;
  assign pdm   = pdm_q;
  assign muted = (state_q == MUTED);

endmodule

// File: tb/tb_audio_out.sv
// Bench for audio_out: directed fade/reset scenarios plus a randomized run against a
// cycle-level reference model built from the sample-rate, fade and sigma-delta rules.
module tb_audio_out;

  localparam int CD = 4;
  localparam int RS = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sample;
  logic       mute;
  logic       sample_ena, pdm, muted;
  logic [3:0] level;

  int total = 0;
  int bad   = 0;

  // Reference model: position in sample period, captured sample, gain, ramp direction
  // (0 = settled, +1 up, -1 down), strobes counted in this ramp step, level and modulator.
  int m_div, m_sq, m_gain, m_dir, m_pc, m_level, m_acc, m_pdm;

  audio_out #(.CLK_DIV(CD), .RAMP_SAMPLES(RS)) dut (
    .clock     (clock),
    .reset     (reset),
    .sample    (sample),
    .mute      (mute),
    .sample_ena(sample_ena),
    .pdm       (pdm),
    .level     (level),
    .muted     (muted)
  );

  always #5 clock = ~clock;

  function automatic int scale(input int s, input int g);
    int p;
    p = (s - 8) * g;
    if (p >= 0) return 8 + p / 16;
    return 8 - ((-p + 15) / 16);
  endfunction

  task automatic model_reset();
    m_div = 0; m_sq = 8; m_gain = 0; m_dir = 0; m_pc = 0;
    m_level = 8; m_acc = 0; m_pdm = 0;
  endtask

  // Advance one clock: the model's next state comes from the inputs held across the edge.
  task automatic tick();
    int nd, nsq, ng, ndir, npc, nl, na, np, sum, want;
    bit ena;
    ena  = (m_div == CD - 1);
    nl   = scale(m_sq, m_gain);
    sum  = m_acc + m_level;
    np   = (sum >= 16) ? 1 : 0;
    na   = sum % 16;
    nd   = (m_div + 1) % CD;
    nsq  = m_sq; ng = m_gain; ndir = m_dir; npc = m_pc;
    if (ena) begin
      nsq  = int'(sample);
      want = mute ? -1 : 1;
      if (m_dir == 0) begin
        if ((want == 1 && m_gain == 0) || (want == -1 && m_gain == 15)) begin
          ndir = want; npc = 0;
        end
      end else if (want != m_dir) begin
        npc  = 0;
        ndir = ((want == -1 && m_gain == 0) || (want == 1 && m_gain == 15)) ? 0 : want;
      end else begin
        npc = m_pc + 1;
        if (npc == RS) begin
          npc = 0;
          ng  = m_gain + m_dir;
          if (ng == 0 || ng == 15) ndir = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    if (reset) model_reset();
    else begin
      m_div = nd; m_sq = nsq; m_gain = ng; m_dir = ndir; m_pc = npc;
      m_level = nl; m_acc = na; m_pdm = np;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Step to just after the next strobe edge, checking the strobe against the model on the way.
  task automatic adv_strobe();
    bit e;
    for (int i = 0; i < 2 * CD; i++) begin
      e = (m_div == CD - 1);
      total++;
      if (sample_ena !== e) begin
        bad++;
        $display("[TB] FAIL strobe_phase: got %b want %b", sample_ena, e);
      end
      tick();
      if (e) return;
    end
    total++; bad++;
    $display("[TB] FAIL strobe_timeout: got none want strobe within %0d clocks", 2 * CD);
  endtask

  task automatic run_to_gain(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_gain == g) return;
      tick();
    end
    total++; bad++;
    $display("[TB] FAIL gain_timeout: got gain %0d want %0d", m_gain, g);
  endtask

  task automatic test_reset();
    reset = 1'b1; mute = 1'b1; sample = 4'd8;
    model_reset();
    tick();
    total++;
    if ({sample_ena, pdm, muted, level} !== {1'b0, 1'b0, 1'b1, 4'd8}) begin
      bad++;
      $display("[TB] FAIL reset_values: got ena=%b pdm=%b muted=%b level=%0d want 0 0 1 8",
               sample_ena, pdm, muted, level);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if (sample_ena !== ((i + 1) % CD == 0)) begin
        bad++;
        $display("[TB] FAIL idle_strobe: clock %0d got %b want %b", i, sample_ena, ((i + 1) % CD == 0));
      end
      total++;
      if (pdm !== (i % 2 == 0)) begin
        bad++;
        $display("[TB] FAIL idle_pdm: clock %0d got %b want %b", i, pdm, (i % 2 == 0));
      end
      total++;
      if (muted !== 1'b1 || level !== 4'd8) begin
        bad++;
        $display("[TB] FAIL idle_level: got muted=%b level=%0d want 1 8", muted, level);
      end
    end
  endtask

  task automatic test_fade_up();
    int ones;
    mute = 1'b0; sample = 4'd15;
    for (int i = 0; i < 36 * CD; i++) begin
      tick();
      total++;
      if (level !== 4'(m_level)) begin
        bad++;
        $display("[TB] FAIL fade_up_level: got %0d want %0d", level, m_level);
      end
    end
    total++;
    if (muted !== 1'b0 || level !== 4'd14) begin
      bad++;
      $display("[TB] FAIL fade_up_end: got muted=%b level=%0d want 0 14", muted, level);
    end
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      ones += int'(pdm);
    end
    total++;
    if (ones != 14) begin
      bad++;
      $display("[TB] FAIL play_density: got %0d ones want 14", ones);
    end
  endtask

  task automatic test_play_zero();
    int ones;
    sample = 4'd0;
    adv_strobe();
    tick();
    total++;
    if (level !== 4'd0) begin
      bad++;
      $display("[TB] FAIL zero_level: got %0d want 0", level);
    end
    tick();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      ones += int'(pdm);
      tick();
    end
    total++;
    if (ones != 0) begin
      bad++;
      $display("[TB] FAIL zero_pdm: got %0d ones want 0", ones);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    mute = 1'b0; sample = 4'd0;
    run_to_gain(5, 400);
    mute = 1'b1;
    adv_strobe();
    for (int g = 4; g >= 0; g--) begin
      adv_strobe();
      adv_strobe();
      tick();
      total++;
      if (level !== 4'(scale(0, g))) begin
        bad++;
        $display("[TB] FAIL rev_level: gain step %0d got %0d want %0d", g, level, scale(0, g));
      end
      total++;
      if (muted !== (g == 0)) begin
        bad++;
        $display("[TB] FAIL rev_muted: gain step %0d got %b want %b", g, muted, (g == 0));
      end
    end
    sample = 4'd11;
    adv_strobe();
    tick();
    total++;
    if (level !== 4'd8) begin
      bad++;
      $display("[TB] FAIL rev_silence: got %0d want 8", level);
    end
  endtask

  task automatic test_mute_glitch();
    mute = 1'b0; sample = 4'd12;
    run_to_gain(15, 600);
    adv_strobe();
    adv_strobe();
    tick();
    mute = 1'b1;
    tick();
    tick();
    mute = 1'b0;
    for (int i = 0; i < 3; i++) adv_strobe();
    tick();
    total++;
    if (muted !== 1'b0 || level !== 4'd11) begin
      bad++;
      $display("[TB] FAIL glitch_play: got muted=%b level=%0d want 0 11", muted, level);
    end
  endtask

  task automatic test_reset_midfade();
    do_reset();
    mute = 1'b0; sample = 4'd15;
    run_to_gain(9, 400);
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({sample_ena, pdm, muted, level} !== {1'b0, 1'b0, 1'b1, 4'd8}) begin
      bad++;
      $display("[TB] FAIL async_reset: got ena=%b pdm=%b muted=%b level=%0d want 0 0 1 8",
               sample_ena, pdm, muted, level);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (sample_ena !== (i == CD - 1)) begin
        bad++;
        $display("[TB] FAIL restart_strobe: clock %0d got %b want %b", i, sample_ena, (i == CD - 1));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    mute = 1'b0;
    sample = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) mute = ~mute;
      if ($urandom_range(0, 7) == 0) sample = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (sample_ena !== (m_div == CD - 1)) begin
        bad++;
        $display("[TB] FAIL rnd_strobe: cycle %0d got %b want %b", i, sample_ena, (m_div == CD - 1));
      end
      total++;
      if (level !== 4'(m_level)) begin
        bad++;
        $display("[TB] FAIL rnd_level: cycle %0d got %0d want %0d", i, level, m_level);
      end
      total++;
      if (pdm !== 1'(m_pdm)) begin
        bad++;
        $display("[TB] FAIL rnd_pdm: cycle %0d got %b want %0d", i, pdm, m_pdm);
      end
      total++;
      if (muted !== (m_dir == 0 && m_gain == 0)) begin
        bad++;
        $display("[TB] FAIL rnd_muted: cycle %0d got %b want %b", i, muted, (m_dir == 0 && m_gain == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_play_zero();
    test_reversal();
    test_mute_glitch();
    test_reset_midfade();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
